muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit implementing all eight RV M-extension ops on WIDTH-bit operands.

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with valid/ready handshakes on both sides.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, next_state;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] hi, lo, b;
   logic [CW-1:0]    counter;
   logic             res_neg, rem_neg;

   logic             signed1, signed2, neg1, neg2, div0, ovf, special, accept;
   logic [WIDTH-1:0] mag1, mag2, special_res;
   logic [WIDTH:0]   msum, shifted, diff;
   logic [WIDTH-1:0] hi_n, lo_n, quot, rem, final_res;
   logic [2*WIDTH-1:0] prod;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && (state == IDLE) && !flush;

   // Operand decode: magnitudes, sign flags and the divide short-circuit cases
   always_comb begin
      signed1 = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                (op == OP_DIV) || (op == OP_REM);
      signed2 = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      neg1    = signed1 && src1[WIDTH-1];
      neg2    = signed2 && src2[WIDTH-1];
      mag1    = neg1 ? -src1 : src1;
      mag2    = neg2 ? -src2 : src2;
      div0    = op[2] && (src2 == '0);
      ovf     = ((op == OP_DIV) || (op == OP_REM)) && (src1 == MIN_VAL) && (src2 == '1);
      special = div0 || ovf;
      special_res = '0;
      if (div0)
         special_res = op[1] ? src1 : '1;
      else if (ovf)
         special_res = op[1] ? '0 : MIN_VAL;
   end

   // One iteration of either the shift-add multiply or the restoring divide
   always_comb begin
      msum    = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
      shifted = {hi, lo[WIDTH-1]};
      diff    = shifted - {1'b0, b};
      if (op_q[2]) begin
         hi_n = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
         lo_n = {lo[WIDTH-2:0], ~diff[WIDTH]};
      end else begin
         hi_n = msum[WIDTH:1];
         lo_n = {msum[0], lo[WIDTH-1:1]};
      end
      prod = res_neg ? -{hi_n, lo_n} : {hi_n, lo_n};
      quot = res_neg ? -lo_n : lo_n;
      rem  = rem_neg ? -hi_n : hi_n;
      case (op_q)
         OP_MUL:                       final_res = prod[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:              final_res = quot;
         default:                      final_res = rem;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Flush overrides every transition, including the output handshake
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid) next_state = special ? DONE : CALC;
         CALC:    if (counter == '0) next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (flush)
         next_state = IDLE;
   end

   // Datapath: load magnitudes on accept, iterate in CALC, write result on the last step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= '0;
         hi      <= '0;
         lo      <= '0;
         b       <= '0;
         counter <= '0;
         res_neg <= 1'b0;
         rem_neg <= 1'b0;
         result  <= '0;
      end else if (!flush) begin
         if (accept) begin
            op_q    <= op;
            res_neg <= neg1 ^ neg2;
            rem_neg <= neg1;
            counter <= CW'(WIDTH-1);
            hi      <= '0;
            lo      <= op[2] ? mag1 : mag2;
            b       <= op[2] ? mag2 : mag1;
            if (special)
               result <= special_res;
         end else if (state == CALC) begin
            hi <= hi_n;
            lo <= lo_n;
            if (counter == '0)
               result <= final_res;
            else
               counter <= counter - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed literal vectors plus randomized
// traffic checked every cycle against a cycle-level behavioural model.
module tb_muldiv_unit;

   logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  op;
   logic [31:0] src1, src2, result;

   int tests_run = 0;
   int tests_failed = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
      .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference arithmetic straight from the RV M-extension definitions
   function automatic logic [31:0] model(logic [2:0] mop, logic [31:0] a, logic [31:0] bv);
      longint sa, sb, ub;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(bv);
      ub = {32'b0, bv};
      p  = '0;
      case (mop)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, bv}; return p[63:32]; end
         3'd4: begin
            if (bv == 0) return 32'hFFFF_FFFF;
            p = sa / sb; return p[31:0];
         end
         3'd5: return (bv == 0) ? 32'hFFFF_FFFF : a / bv;
         3'd6: begin
            if (bv == 0) return a;
            p = sa % sb; return p[31:0];
         end
         default: return (bv == 0) ? a : a % bv;
      endcase
   endfunction

   function automatic logic is_special(logic [2:0] mop, logic [31:0] a, logic [31:0] bv);
      return mop[2] && ((bv == 0) ||
             ((mop == 3'd4 || mop == 3'd6) && a == 32'h8000_0000 && bv == 32'hFFFF_FFFF));
   endfunction

   // Behavioural timing model: busy for 32 edges after accept, or straight to done
   logic        m_busy, m_done;
   int          m_left;
   logic [31:0] m_exp;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_left <= 0;
         m_exp  <= '0;
      end else if (flush) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
      end else if (m_done) begin
         if (out_ready) m_done <= 1'b0;
      end else if (m_busy) begin
         if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
         end
         m_left <= m_left - 1;
      end else if (in_valid) begin
         m_exp <= model(op, src1, src2);
         if (is_special(op, src1, src2))
            m_done <= 1'b1;
         else begin
            m_busy <= 1'b1;
            m_left <= 32;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of handshake and result against the model
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("in_ready", {31'b0, in_ready}, {31'b0, !(m_busy || m_done)});
         checkOutput("out_valid", {31'b0, out_valid}, {31'b0, m_done});
         if (m_done) checkOutput("result", result, m_exp);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] bv);
      int waited = 0;
      while (!in_ready && waited < 300) begin
         step();
         waited++;
      end
      if (!in_ready) checkOutput("accept timeout", {31'b0, in_ready}, 32'd1);
      op = mop;
      src1 = a;
      src2 = bv;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic runVector(input string name, input logic [2:0] mop, input logic [31:0] a,
                            input logic [31:0] bv, input logic [31:0] exp, input int exp_lat);
      int lat = 0;
      checkOutput({"model ", name}, model(mop, a, bv), exp);
      applyStimulus(mop, a, bv);
      while (!out_valid && lat < 200) begin
         step();
         lat++;
      end
      checkOutput({"latency ", name}, lat, exp_lat);
      checkOutput(name, result, exp);
      step();
   endtask

   task automatic drainRandom(input int flush_at);
      int c = 0;
      bit done = 0;
      while (!done) begin
         if (c > 300) begin
            checkOutput("drain timeout", {31'b0, out_valid}, 32'd0);
            done = 1;
         end else if (c == flush_at) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            done = 1;
         end else if (out_valid && out_ready) begin
            step();
            done = 1;
         end else begin
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            c++;
         end
      end
      out_ready = 1'b1;
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] held;
      int fl;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; src1 = '0; src2 = '0;
      step(); step();
      checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset result", result, 32'd0);
      rst = 1'b0;
      step();

      runVector("MUL", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
      runVector("MULH", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
      runVector("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
      runVector("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
      runVector("DIV", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
      runVector("REM", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
      runVector("DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 32);
      runVector("REMU", 3'd7, 32'd100, 32'd7, 32'd2, 32);
      runVector("DIV by zero", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
      runVector("REMU by zero", 3'd7, 32'd5, 32'd0, 32'd5, 0);
      runVector("DIV overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      runVector("REM overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

      // Backpressure: result held while the consumer stalls
      out_ready = 1'b0;
      applyStimulus(3'd0, 32'd1234, 32'd5678);
      for (int i = 0; i < 40 && !out_valid; i++) step();
      held = result;
      checkOutput("bp result", held, 32'd7006652);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         step();
         checkOutput("bp hold", result, 32'd7006652);
         checkOutput("bp out_valid", {31'b0, out_valid}, 32'd1);
         checkOutput("bp in_ready", {31'b0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      checkOutput("bp release", {31'b0, in_ready}, 32'd1);

      // Flush in the middle of a calculation, with a competing in_valid
      applyStimulus(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      for (int i = 0; i < 10; i++) step();
      flush = 1'b1; in_valid = 1'b1; op = 3'd5; src1 = 32'd50; src2 = 32'd5;
      step();
      flush = 1'b0; in_valid = 1'b0;
      checkOutput("flush in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("flush out_valid", {31'b0, out_valid}, 32'd0);
      for (int i = 0; i < 40; i++) step();
      runVector("DIVU after flush", 3'd5, 32'd9, 32'd3, 32'd3, 32);

      // Reset in the middle of a calculation
      applyStimulus(3'd0, 32'hDEAD_BEEF, 32'h1234_5678);
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      #1;
      checkOutput("midreset in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("midreset out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("midreset result", result, 32'd0);
      step();
      rst = 1'b0;
      step();
      runVector("MUL after reset", 3'd0, 32'h0001_0000, 32'h0001_0000, 32'd0, 32);
      runVector("MULHU after reset", 3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1, 32);

      // Randomized traffic with stalls and occasional flushes
      for (int n = 0; n < 150; n++) begin
         applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand());
         fl = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 40)) : -1;
         drainRandom(fl);
         if ($urandom_range(0, 1) == 1) step();
      end
      step(); step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
